// File: rtl/fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl
// Multi-cycle sequencer for the FPU. Accepts an F-type instruction from the
// decode stage, launches the FPU, stalls the integer pipeline for an
// operation-dependent latency, and then issues a one-cycle write-back strobe
// carrying the captured destination register.
//
// Optional feature: define FPU_PERF_CNT_EN to add the performance counters
// o_perf_busy_cycles (BUSY cycles) and o_perf_ops (completed write-backs).
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   i_issue_valid       decode stage holds a valid instruction
//   i_float_ctrl        decoder flag: instruction is F-type
//   i_funct5            FP operation select (instr[31:27])
//   i_rd                destination register of the instruction
//   i_flush             pipeline flush, kills an in-flight op
//   o_issue_ready       controller can accept an F-type instruction (comb)
//   o_fpu_start         one-cycle launch pulse to the FPU
//   o_fpu_op            latched op: 00 add, 01 sub, 10 mul, 11 div
//   o_fpu_abort         one-cycle pulse when flush kills a BUSY op
//   o_stall             freeze PC and IF/ID stage
//   o_wb_en             one-cycle FP result write-back strobe
//   o_wb_rd             destination register qualified by o_wb_en
//   o_illegal_op        one-cycle pulse, one cycle after an unsupported funct5
//   o_dbg_state         FSM state (0 IDLE, 1 BUSY, 2 WB) for checkers
//
// Handshake: an instruction is transferred on a rising edge where
// i_issue_valid & i_float_ctrl & o_issue_ready are all high, funct5 is legal
// and i_flush is low. Valid is not required to be held once ready is low;
// attempts while BUSY are simply ignored because decode is stalled.
// ---------------------------------------------------------------------------
module fpu_issue_ctrl #(
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_issue_valid,
  input  logic        i_float_ctrl,
  input  logic [4:0]  i_funct5,
  input  logic [4:0]  i_rd,
  input  logic        i_flush,
  output logic        o_issue_ready,
  output logic        o_fpu_start,
  output logic [1:0]  o_fpu_op,
  output logic        o_fpu_abort,
  output logic        o_stall,
  output logic        o_wb_en,
  output logic [4:0]  o_wb_rd,
  output logic        o_illegal_op,
`ifdef FPU_PERF_CNT_EN
  output logic [31:0] o_perf_busy_cycles,
  output logic [15:0] o_perf_ops,
`endif
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_fpu_op;
  logic [4:0]       r_wb_rd;
  logic             r_fpu_start;
  logic             r_fpu_abort;
  logic             r_stall;
  logic             r_wb_en;
  logic             r_illegal;

  logic             w_ftype;
  logic             w_legal;
  logic             w_accept;
  logic             w_illegal;
  logic [CNT_W-1:0] w_lat;

  // Legal funct5 values are 00000..00011; the low two bits are the op code.
  assign w_ftype   = i_issue_valid & i_float_ctrl;
  assign w_legal   = ~|i_funct5[4:2];
  assign w_accept  = w_ftype & w_legal & o_issue_ready & ~i_flush;
  assign w_illegal = w_ftype & ~w_legal & o_issue_ready;

  always_comb begin
    w_lat = CNT_W'(ADD_LAT);
    case (i_funct5[1:0])
      2'b10:   w_lat = CNT_W'(MUL_LAT);
      2'b11:   w_lat = CNT_W'(DIV_LAT);
      default: w_lat = CNT_W'(ADD_LAT);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fpu_op    <= 2'b00;
      r_wb_rd     <= 5'd0;
      r_fpu_start <= 1'b0;
      r_fpu_abort <= 1'b0;
      r_stall     <= 1'b0;
      r_wb_en     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_fpu_start <= 1'b0;
      r_fpu_abort <= 1'b0;
      r_wb_en     <= 1'b0;
      r_illegal   <= w_illegal;
      case (r_state)
        S_BUSY: begin
          if (i_flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_fpu_abort <= 1'b1;
            r_stall     <= 1'b0;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state <= S_WB;
            r_cnt   <= '0;
            r_wb_en <= 1'b1;
            r_stall <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_stall <= 1'b1;
          end
        end
        default: begin
          // IDLE and WB both accept; a WB-cycle accept gives back-to-back issue.
          if (w_accept) begin
            r_state     <= S_BUSY;
            r_cnt       <= w_lat;
            r_fpu_op    <= i_funct5[1:0];
            r_wb_rd     <= i_rd;
            r_fpu_start <= 1'b1;
            r_stall     <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef FPU_PERF_CNT_EN
  logic [31:0] r_perf_busy;
  logic [15:0] r_perf_ops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_busy <= 32'd0;
      r_perf_ops  <= 16'd0;
    end else begin
      if (r_state == S_BUSY) r_perf_busy <= r_perf_busy + 32'd1;
      if (r_wb_en)           r_perf_ops  <= r_perf_ops + 16'd1;
    end
  end

  assign o_perf_busy_cycles = r_perf_busy;
  assign o_perf_ops         = r_perf_ops;
`endif

  assign o_issue_ready = (r_state != S_BUSY);
  assign o_fpu_start   = r_fpu_start;
  assign o_fpu_op      = r_fpu_op;
  assign o_fpu_abort   = r_fpu_abort;
  assign o_stall       = r_stall;
  assign o_wb_en       = r_wb_en;
  assign o_wb_rd       = r_wb_rd;
  assign o_illegal_op  = r_illegal;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpu_issue_ctrl
// Directed bench for fpu_issue_ctrl: a per-cycle vector table for the
// single-issue, back-to-back, illegal and ignored-issue cases, followed by
// hand-written sequences for the long divide with held valid, flush in BUSY,
// asynchronous reset mid-operation and (optionally) the perf counters.
// ---------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        float_ctrl;
  logic [4:0]  funct5;
  logic [4:0]  rd;
  logic        flush;
  logic        issue_ready;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic        fpu_abort;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic        illegal_op;
  logic [1:0]  dbg_state;
`ifdef FPU_PERF_CNT_EN
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_ops;
`endif

  int n_checks;
  int n_pass;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fpu_issue_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_issue_valid      (issue_valid),
    .i_float_ctrl       (float_ctrl),
    .i_funct5           (funct5),
    .i_rd               (rd),
    .i_flush            (flush),
    .o_issue_ready      (issue_ready),
    .o_fpu_start        (fpu_start),
    .o_fpu_op           (fpu_op),
    .o_fpu_abort        (fpu_abort),
    .o_stall            (stall),
    .o_wb_en            (wb_en),
    .o_wb_rd            (wb_rd),
    .o_illegal_op       (illegal_op),
`ifdef FPU_PERF_CNT_EN
    .o_perf_busy_cycles (perf_busy_cycles),
    .o_perf_ops         (perf_ops),
`endif
    .o_dbg_state        (dbg_state)
  );

  // Output bundle: {ready, start, op[1:0], abort, stall, wb_en, wb_rd[4:0], illegal, state[1:0]}
  typedef struct {
    logic        iv;
    logic        fc;
    logic [4:0]  f5;
    logic [4:0]  rd;
    logic        fl;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] mk(input logic rdy, input logic st, input logic [1:0] op,
                                     input logic ab, input logic stl, input logic wb,
                                     input logic [4:0] wrd, input logic ill, input logic [1:0] s);
    return {rdy, st, op, ab, stl, wb, wrd, ill, s};
  endfunction

  function automatic logic [14:0] act_bundle();
    return {issue_ready, fpu_start, fpu_op, fpu_abort, stall, wb_en, wb_rd, illegal_op, dbg_state};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic iv, input logic fc, input logic [4:0] f5,
                       input logic [4:0] r, input logic fl);
    issue_valid = iv;
    float_ctrl  = fc;
    funct5      = f5;
    rd          = r;
    flush       = fl;
  endtask

  // Inputs set mid-cycle, sampled at the next rising edge; outputs read 1 ns later.
  task automatic step(input logic iv, input logic fc, input logic [4:0] f5,
                      input logic [4:0] r, input logic fl);
    @(negedge clk);
    drive(iv, fc, f5, r, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic add_vec(input logic iv, input logic fc, input logic [4:0] f5,
                         input logic [4:0] r, input logic fl, input logic [14:0] e);
    vec_t v;
    v.iv = iv; v.fc = fc; v.f5 = f5; v.rd = r; v.fl = fl; v.exp = e;
    vecs.push_back(v);
  endtask

  int cnt_stall, cnt_start, cnt_wb, cnt_abort;
  int wb_cycle;
  logic [4:0] seen_rd;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);

    // ---- vector table ----
    // fadd rd5: start in cycle 1, stall cycles 1-3, wb in cycle 4
    add_vec(1, 1, 5'b00000, 5'd5, 0, mk(0, 1, 2'd0, 0, 1, 0, 5'd5, 0, 2'd1));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(0, 0, 2'd0, 0, 1, 0, 5'd5, 0, 2'd1));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(0, 0, 2'd0, 0, 1, 0, 5'd5, 0, 2'd1));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(1, 0, 2'd0, 0, 0, 1, 5'd5, 0, 2'd2));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(1, 0, 2'd0, 0, 0, 0, 5'd5, 0, 2'd0));
    // fmul rd3, then fsub rd4 presented in the WB cycle
    add_vec(1, 1, 5'b00010, 5'd3, 0, mk(0, 1, 2'd2, 0, 1, 0, 5'd3, 0, 2'd1));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(0, 0, 2'd2, 0, 1, 0, 5'd3, 0, 2'd1));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(0, 0, 2'd2, 0, 1, 0, 5'd3, 0, 2'd1));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(0, 0, 2'd2, 0, 1, 0, 5'd3, 0, 2'd1));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(1, 0, 2'd2, 0, 0, 1, 5'd3, 0, 2'd2));
    add_vec(1, 1, 5'b00001, 5'd4, 0, mk(0, 1, 2'd1, 0, 1, 0, 5'd4, 0, 2'd1));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(0, 0, 2'd1, 0, 1, 0, 5'd4, 0, 2'd1));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(0, 0, 2'd1, 0, 1, 0, 5'd4, 0, 2'd1));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(1, 0, 2'd1, 0, 0, 1, 5'd4, 0, 2'd2));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(1, 0, 2'd1, 0, 0, 0, 5'd4, 0, 2'd0));
    // illegal funct5 00111: one-cycle pulse, nothing else changes
    add_vec(1, 1, 5'b00111, 5'd7, 0, mk(1, 0, 2'd1, 0, 0, 0, 5'd4, 1, 2'd0));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(1, 0, 2'd1, 0, 0, 0, 5'd4, 0, 2'd0));
    // non-F-type fdiv encoding is ignored
    add_vec(1, 0, 5'b00011, 5'd8, 0, mk(1, 0, 2'd1, 0, 0, 0, 5'd4, 0, 2'd0));
    // flush in IDLE blocks the accept
    add_vec(1, 1, 5'b00000, 5'd6, 1, mk(1, 0, 2'd1, 0, 0, 0, 5'd4, 0, 2'd0));
    add_vec(0, 0, 5'd0, 5'd0, 0,     mk(1, 0, 2'd1, 0, 0, 0, 5'd4, 0, 2'd0));

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(act_bundle()), 32'(mk(1, 0, 2'd0, 0, 0, 0, 5'd0, 0, 2'd0)));
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].iv, vecs[i].fc, vecs[i].f5, vecs[i].rd, vecs[i].fl);
      chk($sformatf("vec%0d", i), 32'(act_bundle()), 32'(vecs[i].exp));
    end

    // ---- fdiv rd9 with issue held high through BUSY (other rd shown while busy) ----
    cnt_stall = 0; cnt_start = 0; cnt_wb = 0; wb_cycle = 0; seen_rd = 5'd0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 1)       step(1, 1, 5'b00011, 5'd9, 0);
      else if (c <= 13) step(1, 1, 5'b00010, 5'd13, 0);
      else              idle_step();
      if (stall)     cnt_stall++;
      if (fpu_start) cnt_start++;
      if (wb_en) begin cnt_wb++; wb_cycle = c; seen_rd = wb_rd; end
    end
    chk("div_stall_cycles", 32'(cnt_stall), 32'd12);
    chk("div_start_count",  32'(cnt_start), 32'd1);
    chk("div_wb_count",     32'(cnt_wb),    32'd1);
    chk("div_wb_cycle",     32'(wb_cycle),  32'd13);
    chk("div_wb_rd",        32'(seen_rd),   32'd9);
    chk("div_op_held",      32'(fpu_op),    32'd3);

    // ---- fdiv rd2, flush in BUSY cycle 5 ----
    step(1, 1, 5'b00011, 5'd2, 0);
    for (int c = 2; c <= 5; c++) idle_step();
    chk("flush_pre_stall", 32'(stall), 32'd1);
    step(0, 0, 5'd0, 5'd0, 1);
    chk("flush_abort", 32'(fpu_abort), 32'd1);
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_ready", 32'(issue_ready), 32'd1);
    cnt_wb = 0; cnt_abort = 0;
    for (int c = 0; c < 15; c++) begin
      idle_step();
      if (wb_en)     cnt_wb++;
      if (fpu_abort) cnt_abort++;
    end
    chk("flush_no_wb", 32'(cnt_wb), 32'd0);
    chk("flush_abort_single", 32'(cnt_abort), 32'd0);

    // ---- async reset in BUSY cycle 2 of fmul rd11 ----
    step(1, 1, 5'b00010, 5'd11, 0);
    idle_step();
    chk("rst_pre_busy", 32'(dbg_state), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_vals", 32'(act_bundle()), 32'(mk(1, 0, 2'd0, 0, 0, 0, 5'd0, 0, 2'd0)));
    @(negedge clk);
    rst_n = 1'b1;
    cnt_wb = 0; cnt_stall = 0;
    for (int c = 0; c < 10; c++) begin
      idle_step();
      if (wb_en) cnt_wb++;
      if (stall) cnt_stall++;
    end
    chk("rst_no_wb", 32'(cnt_wb), 32'd0);
    chk("rst_no_stall", 32'(cnt_stall), 32'd0);

`ifdef FPU_PERF_CNT_EN
    // ---- perf counters: fadd then fmul ----
    step(1, 1, 5'b00000, 5'd1, 0);
    for (int c = 0; c < 4; c++) idle_step();
    step(1, 1, 5'b00010, 5'd2, 0);
    for (int c = 0; c < 5; c++) idle_step();
    chk("perf_busy_cycles", perf_busy_cycles, 32'd7);
    chk("perf_ops", 32'(perf_ops), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
